// File: rtl/sw_max_score_tracker.sv
// Max-score tracker behind the Smith-Waterman array: 2-stage PE max-reduction, per-query best tracking,
// one-entry result register with valid/rdy. Latency: last beat accepted at N -> result valid at N+3.
module sw_max_score_tracker #(
  parameter int NUM_PES     = 64,
  parameter int WIDTH       = 10,
  parameter int PES_PER_GRP = 8,
  parameter int COL_W       = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic [NUM_PES*WIDTH-1:0]     V_in,
  input  logic                         v_valid_in,
  input  logic                         col_first_in,
  input  logic                         col_last_in,
  output logic [WIDTH-1:0]             score_out,
  output logic [$clog2(NUM_PES)-1:0]   pe_idx_out,
  output logic [COL_W-1:0]             col_idx_out,
  output logic                         result_valid_out,
  input  logic                         result_rdy_in,
  output logic                         stall_req_out,
  output logic                         drop_err_out
);

  localparam int PE_W    = $clog2(NUM_PES);
  localparam int NUM_GRP = NUM_PES / PES_PER_GRP;
  localparam int LG_W    = (PES_PER_GRP > 1) ? $clog2(PES_PER_GRP) : 1;

  typedef enum logic {IDLE, TRACK} state_t;

  state_t            r_state, w_state_nx;
  logic [COL_W-1:0]  r_col_cnt, w_col_tag;
  logic              w_accept;

  logic [WIDTH-1:0]  w_gmax [NUM_GRP];
  logic [LG_W-1:0]   w_gidx [NUM_GRP];
  logic [WIDTH-1:0]  r_s1_gmax [NUM_GRP];
  logic [LG_W-1:0]   r_s1_gidx [NUM_GRP];
  logic              r_s1_vld, r_s1_first, r_s1_last;
  logic [COL_W-1:0]  r_s1_col;

  logic [WIDTH-1:0]  w_cmax;
  logic [PE_W-1:0]   w_cpe;
  logic [WIDTH-1:0]  r_s2_max;
  logic [PE_W-1:0]   r_s2_pe;
  logic              r_s2_vld, r_s2_first, r_s2_last;
  logic [COL_W-1:0]  r_s2_col;

  logic [WIDTH-1:0]  r_best, w_cand_score;
  logic [PE_W-1:0]   r_best_pe, w_cand_pe;
  logic [COL_W-1:0]  r_best_col, w_cand_col;
  logic              w_take, w_load;

  logic [WIDTH-1:0]  r_score;
  logic [PE_W-1:0]   r_pe;
  logic [COL_W-1:0]  r_col;
  logic              r_res_vld, r_drop_err, w_drain;

  assign w_accept  = v_valid_in & ~stall;
  assign w_col_tag = col_first_in ? '0 : r_col_cnt;

  // Strict '>' while scanning upward keeps the lowest index on ties.
  always_comb begin
    for (int g = 0; g < NUM_GRP; g++) begin
      w_gmax[g] = V_in[g*PES_PER_GRP*WIDTH +: WIDTH];
      w_gidx[g] = '0;
      for (int j = 1; j < PES_PER_GRP; j++) begin
        if (V_in[(g*PES_PER_GRP+j)*WIDTH +: WIDTH] > w_gmax[g]) begin
          w_gmax[g] = V_in[(g*PES_PER_GRP+j)*WIDTH +: WIDTH];
          w_gidx[g] = LG_W'(j);
        end
      end
    end
  end

  always_comb begin
    w_cmax = r_s1_gmax[0];
    w_cpe  = PE_W'(r_s1_gidx[0]);
    for (int g = 1; g < NUM_GRP; g++) begin
      if (r_s1_gmax[g] > w_cmax) begin
        w_cmax = r_s1_gmax[g];
        w_cpe  = PE_W'(g*PES_PER_GRP) + PE_W'(r_s1_gidx[g]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col_cnt  <= '0;
      r_s1_vld   <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_col   <= '0;
      for (int g = 0; g < NUM_GRP; g++) begin
        r_s1_gmax[g] <= '0;
        r_s1_gidx[g] <= '0;
      end
      r_s2_vld   <= 1'b0;
      r_s2_first <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_col   <= '0;
      r_s2_max   <= '0;
      r_s2_pe    <= '0;
    end else if (!stall) begin
      if (w_accept) begin
        if (col_first_in)         r_col_cnt <= COL_W'(1);
        else if (r_col_cnt != '1) r_col_cnt <= r_col_cnt + COL_W'(1);
      end
      r_s1_vld   <= v_valid_in;
      r_s1_first <= col_first_in;
      r_s1_last  <= col_last_in;
      r_s1_col   <= w_col_tag;
      for (int g = 0; g < NUM_GRP; g++) begin
        r_s1_gmax[g] <= w_gmax[g];
        r_s1_gidx[g] <= w_gidx[g];
      end
      r_s2_vld   <= r_s1_vld;
      r_s2_first <= r_s1_first;
      r_s2_last  <= r_s1_last;
      r_s2_col   <= r_s1_col;
      r_s2_max   <= w_cmax;
      r_s2_pe    <= w_cpe;
    end
  end

  // A first-column beat seeds the best unconditionally; otherwise only a strictly larger max replaces it.
  always_comb begin
    w_state_nx = r_state;
    w_take     = 1'b0;
    w_load     = 1'b0;
    if (r_s2_first || (r_s2_max > r_best)) begin
      w_cand_score = r_s2_max;
      w_cand_pe    = r_s2_pe;
      w_cand_col   = r_s2_col;
    end else begin
      w_cand_score = r_best;
      w_cand_pe    = r_best_pe;
      w_cand_col   = r_best_col;
    end
    case (r_state)
      IDLE: begin
        if (r_s2_vld && !stall && r_s2_first) begin
          w_take = 1'b1;
          if (r_s2_last) w_load = 1'b1;
          else           w_state_nx = TRACK;
        end
      end
      TRACK: begin
        if (r_s2_vld && !stall) begin
          w_take = 1'b1;
          if (r_s2_last) begin
            w_load     = 1'b1;
            w_state_nx = IDLE;
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign w_drain = r_res_vld & result_rdy_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_best     <= '0;
      r_best_pe  <= '0;
      r_best_col <= '0;
      r_score    <= '0;
      r_pe       <= '0;
      r_col      <= '0;
      r_res_vld  <= 1'b0;
      r_drop_err <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (w_take) begin
        r_best     <= w_cand_score;
        r_best_pe  <= w_cand_pe;
        r_best_col <= w_cand_col;
      end
      // Result register runs independent of stall so the consumer can drain while the engine is frozen.
      if (w_load) begin
        if (!r_res_vld || w_drain) begin
          r_score   <= w_cand_score;
          r_pe      <= w_cand_pe;
          r_col     <= w_cand_col;
          r_res_vld <= 1'b1;
        end else begin
          r_drop_err <= 1'b1;
        end
      end else if (w_drain) begin
        r_res_vld <= 1'b0;
      end
    end
  end

  assign score_out        = r_score;
  assign pe_idx_out       = r_pe;
  assign col_idx_out      = r_col;
  assign result_valid_out = r_res_vld;
  assign drop_err_out     = r_drop_err;
  assign stall_req_out    = r_res_vld & ~result_rdy_in;

endmodule
